gpr_file: RTL and testbench
===========================

# gpr_file

Parametrised general-purpose register file, the successor to the single 16-bit GPR. It replaces one register with DEPTH registers of WIDTH bits. Writes come from the S-bus. There are two registered read ports, one driving the A-bus and one driving the B-bus, with optional write-to-read bypass. The block also provides a software-visible zeroing sweep and a stepped debug readback port, so the board interface can show any register on LEDs.

## Interface
Parameters:
- WIDTH, 16, data width of each register and of every bus.
- DEPTH, 8, number of registers; must be ≥ 2. Address width AW = clog2(DEPTH).
- BYPASS, 1, controls same-cycle write/read collisions. 1: the read port returns the data being written. 0: it returns the old contents.
- R0_ZERO, 0. When 1, register 0 always reads 0 and writes to it are discarded.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- CLR  in  1  reset, synchronous, active-high.
- SR  in  1  store enable; write S_bus into reg[S_sel].
- S_sel  in  AW  write address.
- S_bus  in  WIDTH  write data.
- RA  in  1  A-bus read enable.
- A_sel  in  AW  A read address.
- A_bus  out  WIDTH  registered A read data.
- RB  in  1  B-bus read enable.
- B_sel  in  AW  B read address.
- B_bus  out  WIDTH  registered B read data.
- INIT_req  in  1  single-cycle pulse; starts the zeroing sweep.
- INIT_busy  out  1  high while the sweep runs.
- DBG_step  in  1  single-cycle pulse (debounced by the caller); advances the debug pointer.
- DBG_sel  out  AW  current debug pointer.
- DBG_data  out  WIDTH  registered contents of reg[DBG_sel].

## Operation
- Reset (CLR=1 at an edge): every register is 0. A_bus, B_bus, DBG_data, DBG_sel and INIT_busy are 0. The FSM is in IDLE and the sweep pointer is 0. CLR overrides every other input, including a sweep in progress.
- Write: in IDLE, SR=1 writes reg[S_sel] ← S_bus at the edge. The write is discarded when:
  - S_sel ≥ DEPTH, or
  - R0_ZERO=1 and S_sel=0.
- Read A: at an edge with RA=1, A_bus ← reg[A_sel]. At an edge with RA=0, A_bus ← 0. This is the registered form of the old RA-gated output.
- Read B: identical to read A, using RB and B_sel.
- Reads of address ≥ DEPTH return 0. With R0_ZERO=1, reads of address 0 return 0.
- Collision (SR=1 with a read address equal to S_sel, write not discarded): the read port loads S_bus when BYPASS=1 and the old value when BYPASS=0. Both read ports may target the same address.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE → SWEEP on INIT_req=1; the pointer is set to 0.
  - In SWEEP, each edge clears reg[ptr] and then increments ptr.
  - When reg[DEPTH-1] is cleared, SWEEP → IDLE.
  - INIT_busy is high for exactly the DEPTH cycles spent in SWEEP.
- During SWEEP:
  - SR is ignored; the write is dropped, not queued.
  - INIT_req is ignored.
  - Reads and debug continue and see the sweep's progress; bypass never applies to sweep writes.
- Debug pointer: on DBG_step=1, DBG_sel increments and wraps from DEPTH-1 to 0. Wrap is explicit, so non-power-of-two DEPTH is supported.
- DBG_data ← reg[DBG_sel] on every edge, using the pre-step pointer value. It always reflects register contents, with R0_ZERO applied. Bypass does not apply.

## Timing
- Write-to-storage: 1 edge. A read issued on the cycle after a write returns the new value regardless of BYPASS.
- Read latency: A_bus and B_bus are valid 1 cycle after the enable/address cycle, and hold until the next edge.
- INIT_req to INIT_busy=1: 1 edge. Total sweep: DEPTH cycles. The edge after INIT_busy falls accepts SR writes again.
- DBG_step to new DBG_sel: 1 edge. The matching DBG_data appears 1 edge after that.
- CLR mid-sweep: the next edge forces IDLE, clears all registers and drops INIT_busy.

## Test plan
- Reset then write/read: CLR=1, release. SR=1, S_sel=3, S_bus=0xA5A5. Next cycle RA=1, A_sel=3 → A_bus=0xA5A5 one cycle later. RA=0 → A_bus=0 the following cycle.
- Collision: reg[2]=0x1111. Same cycle SR=1, S_sel=2, S_bus=0x2222, RA=RB=1, A_sel=B_sel=2. Expect A_bus=B_bus=0x2222 with BYPASS=1, and 0x1111 with BYPASS=0.
- R0_ZERO=1: write 0xFFFF to address 0 → A read of address 0 returns 0. Address 1 write/read behaves normally.
- Sweep: fill all 8 registers with 0xBEEF, then pulse INIT_req. Expect INIT_busy high for exactly 8 cycles. An SR write issued mid-sweep is dropped. All reads afterwards return 0.
- CLR at sweep cycle 3 of DEPTH=8: INIT_busy drops after 1 edge and all registers are 0. A following INIT_req restarts the sweep from pointer 0.
- Debug wrap with DEPTH=5: reg[i]=i+1. Pulse DBG_step 6 times. Expect DBG_sel = 1,2,3,4,0,1, with DBG_data following one cycle later as 2,3,4,5,1,2.

Source files
------------

// File: rtl/gpr_file_if.sv
// S-bus write port and A/B-bus read ports of the general-purpose register file.
interface gpr_file_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             SR;
  logic [AW-1:0]    S_sel;
  logic [WIDTH-1:0] S_bus;
  logic             RA;
  logic [AW-1:0]    A_sel;
  logic [WIDTH-1:0] A_bus;
  logic             RB;
  logic [AW-1:0]    B_sel;
  logic [WIDTH-1:0] B_bus;

  modport master (
    output SR, S_sel, S_bus, RA, A_sel, RB, B_sel,
    input  A_bus, B_bus
  );

  modport slave (
    input  SR, S_sel, S_bus, RA, A_sel, RB, B_sel,
    output A_bus, B_bus
  );
endinterface

// File: rtl/gpr_file.sv
// Parametrised register file: one S-bus write port, two registered read
// ports (A/B) with optional write bypass, a zeroing sweep and a stepped
// debug readback port.
module gpr_file #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             CLR,
  gpr_file_if.slave        bus,
  input  logic             INIT_req,
  output logic             INIT_busy,
  input  logic             DBG_step,
  output logic [AW-1:0]    DBG_sel,
  output logic [WIDTH-1:0] DBG_data
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q;
  logic [AW-1:0]    ptr_q;
  logic             busy_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [AW-1:0]    dbg_sel_q, dbg_sel_d;
  logic [WIDTH-1:0] dbg_data_q, dbg_data_d;
  logic             wr_en;

  // Address maps to a real, writable/readable register (not past DEPTH,
  // not the hard-wired zero register).
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return (32'(addr) < DEPTH) && !((R0_ZERO != 0) && (addr == '0));
  endfunction

  // Current register contents as seen by any read port.
  function automatic logic [WIDTH-1:0] rd_word(input logic [AW-1:0] addr);
    return addr_ok(addr) ? mem_q[addr] : '0;
  endfunction

  // Writes are accepted only outside the sweep and to a valid address.
  assign wr_en = (state_q == IDLE) && bus.SR && addr_ok(bus.S_sel);

  // Next values for the read ports and the debug pointer/data.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    a_d        = '0;
    b_d        = '0;
    dbg_sel_d  = dbg_sel_q;
    dbg_data_d = rd_word(dbg_sel_q);
    if (bus.RA) begin
      a_d = ((BYPASS != 0) && wr_en && (bus.A_sel == bus.S_sel)) ? bus.S_bus
                                                                 : rd_word(bus.A_sel);
    end
    if (bus.RB) begin
      b_d = ((BYPASS != 0) && wr_en && (bus.B_sel == bus.S_sel)) ? bus.S_bus
                                                                 : rd_word(bus.B_sel);
    end
    if (DBG_step) begin
      dbg_sel_d = (dbg_sel_q == LAST) ? '0 : dbg_sel_q + AW'(1);
    end
  end

  // Register storage and the IDLE/SWEEP zeroing FSM.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      // NOTE: the storage array is reset on purpose: software relies on
      // CLR leaving every register at zero, which costs a reset per bit.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every
      // register samples pre-edge values, whatever the statement order.
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            mem_q[bus.S_sel] <= bus.S_bus;
          end
          if (INIT_req) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          mem_q[ptr_q] <= '0;
          if (ptr_q == LAST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Registered read ports and debug readback.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      a_q        <= '0;
      b_q        <= '0;
      dbg_sel_q  <= '0;
      dbg_data_q <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      dbg_sel_q  <= dbg_sel_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign bus.A_bus = a_q;
  assign bus.B_bus = b_q;
  assign INIT_busy = busy_q;
  assign DBG_sel   = dbg_sel_q;
  assign DBG_data  = dbg_data_q;

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: four configurations driven by shared stimulus
// (default, BYPASS=0, R0_ZERO=1, DEPTH=5), each compared every cycle
// against a behavioural model, plus directed checks of the key scenarios.
module tb_gpr_file;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          clr, sr, ra, rb, init_req, dbg_step;
  logic [AW-1:0] s_sel, a_sel, b_sel;
  logic [W-1:0]  s_bus;

  logic [W-1:0]  a_obs [N];
  logic [W-1:0]  b_obs [N];
  logic [W-1:0]  d_obs [N];
  logic [AW-1:0] sel_obs [N];
  logic          busy_obs [N];

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int D  = (k == 3) ? 5 : 8;
    localparam int BY = (k == 1) ? 0 : 1;
    localparam int RZ = (k == 2) ? 1 : 0;

    gpr_file_if #(.WIDTH(W), .DEPTH(D)) bus_if ();
    logic [AW-1:0] dsel;
    logic [W-1:0]  ddata;
    logic          busy;

    assign bus_if.SR    = sr;
    assign bus_if.S_sel = s_sel;
    assign bus_if.S_bus = s_bus;
    assign bus_if.RA    = ra;
    assign bus_if.A_sel = a_sel;
    assign bus_if.RB    = rb;
    assign bus_if.B_sel = b_sel;

    gpr_file #(.WIDTH(W), .DEPTH(D), .BYPASS(BY), .R0_ZERO(RZ)) u_dut (
      .CLK      (CLK),
      .CLR      (clr),
      .bus      (bus_if),
      .INIT_req (init_req),
      .INIT_busy(busy),
      .DBG_step (dbg_step),
      .DBG_sel  (dsel),
      .DBG_data (ddata)
    );

    assign a_obs[k]    = bus_if.A_bus;
    assign b_obs[k]    = bus_if.B_bus;
    assign d_obs[k]    = ddata;
    assign sel_obs[k]  = dsel;
    assign busy_obs[k] = busy;
  end

  // Reference model: per-configuration register array, read outputs,
  // debug pointer and number of sweep cycles still to run.
  int cfg_d   [N] = '{8, 8, 8, 5};
  int cfg_byp [N] = '{1, 0, 1, 1};
  int cfg_r0  [N] = '{0, 0, 1, 0};

  logic [W-1:0] m_mem [N][8];
  logic [W-1:0] m_a [N];
  logic [W-1:0] m_b [N];
  logic [W-1:0] m_d [N];
  int           m_sel [N];
  int           m_left [N];

  int checks   = 0;
  int failures = 0;

  function automatic logic [W-1:0] m_read(input int k, input int addr);
    if (addr >= cfg_d[k] || (cfg_r0[k] != 0 && addr == 0)) return '0;
    return m_mem[k][addr];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      int           sa, aa, ba;
      bit           sweeping, wr;
      logic [W-1:0] na, nb, nd;
      sa = s_sel;
      aa = a_sel;
      ba = b_sel;
      if (clr) begin
        for (int i = 0; i < 8; i++) m_mem[k][i] = '0;
        m_a[k] = '0; m_b[k] = '0; m_d[k] = '0;
        m_sel[k] = 0; m_left[k] = 0;
      end else begin
        sweeping = (m_left[k] > 0);
        wr = !sweeping && sr && (sa < cfg_d[k]) && !(cfg_r0[k] != 0 && sa == 0);
        na = '0;
        nb = '0;
        if (ra) na = (cfg_byp[k] != 0 && wr && aa == sa) ? s_bus : m_read(k, aa);
        if (rb) nb = (cfg_byp[k] != 0 && wr && ba == sa) ? s_bus : m_read(k, ba);
        nd = m_read(k, m_sel[k]);
        if (dbg_step) m_sel[k] = (m_sel[k] + 1) % cfg_d[k];
        if (wr) m_mem[k][sa] = s_bus;
        if (sweeping) begin
          m_mem[k][cfg_d[k] - m_left[k]] = '0;
          m_left[k]--;
        end else if (init_req) begin
          m_left[k] = cfg_d[k];
        end
        m_a[k] = na;
        m_b[k] = nb;
        m_d[k] = nd;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic compare_all(input string ph);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s u%0d A_bus", ph, k), 32'(a_obs[k]), 32'(m_a[k]));
      chk($sformatf("%s u%0d B_bus", ph, k), 32'(b_obs[k]), 32'(m_b[k]));
      chk($sformatf("%s u%0d DBG_data", ph, k), 32'(d_obs[k]), 32'(m_d[k]));
      chk($sformatf("%s u%0d DBG_sel", ph, k), 32'(sel_obs[k]), 32'(m_sel[k]));
      chk($sformatf("%s u%0d INIT_busy", ph, k), 32'(busy_obs[k]), 32'(m_left[k] > 0));
    end
  endtask

  task automatic cycle(input string ph);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all(ph);
  endtask

  initial begin
    int exp_sel  [6] = '{1, 2, 3, 4, 0, 1};
    int exp_data [6] = '{2, 3, 4, 5, 1, 2};
    int cnt, guard;

    clr = 1'b1; sr = 1'b0; ra = 1'b0; rb = 1'b0; init_req = 1'b0; dbg_step = 1'b0;
    s_sel = '0; a_sel = '0; b_sel = '0; s_bus = '0;

    // Reset
    cycle("reset");
    cycle("reset");
    chk("reset A_bus", 32'(a_obs[0]), 32'h0);
    chk("reset INIT_busy", 32'(busy_obs[0]), 32'h0);
    clr = 1'b0;

    // Basic write then read, then RA=0 returns zero
    sr = 1'b1; s_sel = 3'd3; s_bus = 16'hA5A5;
    cycle("write3");
    sr = 1'b0; ra = 1'b1; a_sel = 3'd3;
    cycle("read3");
    chk("read3 A_bus", 32'(a_obs[0]), 32'hA5A5);
    ra = 1'b0;
    cycle("ra_off");
    chk("ra_off A_bus", 32'(a_obs[0]), 32'h0);

    // Collision on address 2, both read ports
    sr = 1'b1; s_sel = 3'd2; s_bus = 16'h1111;
    cycle("pre_coll");
    s_bus = 16'h2222; ra = 1'b1; rb = 1'b1; a_sel = 3'd2; b_sel = 3'd2;
    cycle("coll");
    chk("coll bypass A", 32'(a_obs[0]), 32'h2222);
    chk("coll bypass B", 32'(b_obs[0]), 32'h2222);
    chk("coll nobypass A", 32'(a_obs[1]), 32'h1111);
    chk("coll nobypass B", 32'(b_obs[1]), 32'h1111);
    sr = 1'b0;
    cycle("post_coll");
    chk("post_coll nobypass A", 32'(a_obs[1]), 32'h2222);

    // R0_ZERO: writes to 0 discarded, address 1 normal
    ra = 1'b0; rb = 1'b0;
    sr = 1'b1; s_sel = 3'd0; s_bus = 16'hFFFF;
    cycle("r0_wr");
    sr = 1'b0; ra = 1'b1; a_sel = 3'd0;
    cycle("r0_rd");
    chk("r0 read zero", 32'(a_obs[2]), 32'h0);
    chk("r0 normal cfg", 32'(a_obs[0]), 32'hFFFF);
    sr = 1'b1; s_sel = 3'd1; s_bus = 16'h1234; ra = 1'b0;
    cycle("r1_wr");
    sr = 1'b0; ra = 1'b1; a_sel = 3'd1;
    cycle("r1_rd");
    chk("r0cfg addr1", 32'(a_obs[2]), 32'h1234);
    ra = 1'b0;

    // Sweep: fill with 0xBEEF, count busy cycles, drop a mid-sweep write
    for (int i = 0; i < 8; i++) begin
      sr = 1'b1; s_sel = AW'(i); s_bus = 16'hBEEF;
      cycle("fill");
    end
    sr = 1'b0; init_req = 1'b1;
    cycle("init");
    init_req = 1'b0;
    cnt = 0; guard = 0;
    while (busy_obs[0] === 1'b1 && guard < 20) begin
      cnt++;
      sr = (cnt == 3); s_sel = 3'd0; s_bus = 16'hDEAD;
      cycle("sweep");
      guard++;
    end
    sr = 1'b0;
    chk("sweep busy cycles", 32'(cnt), 32'd8);
    for (int i = 0; i < 8; i++) begin
      ra = 1'b1; a_sel = AW'(i); rb = 1'b1; b_sel = AW'(7 - i);
      cycle("post_sweep");
      chk($sformatf("post_sweep reg%0d", i), 32'(a_obs[0]), 32'h0);
    end
    ra = 1'b0; rb = 1'b0;

    // CLR in the middle of a sweep, then restart
    for (int i = 0; i < 8; i++) begin
      sr = 1'b1; s_sel = AW'(i); s_bus = W'($urandom_range(1, 16'hFFFF));
      cycle("refill");
    end
    sr = 1'b0; init_req = 1'b1;
    cycle("init2");
    init_req = 1'b0;
    cycle("sweep2");
    cycle("sweep2");
    clr = 1'b1;
    cycle("clr_mid");
    chk("clr_mid INIT_busy", 32'(busy_obs[0]), 32'h0);
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra = 1'b1; a_sel = AW'(i);
      cycle("post_clr");
      chk($sformatf("post_clr reg%0d", i), 32'(a_obs[0]), 32'h0);
    end
    ra = 1'b0; init_req = 1'b1;
    cycle("init3");
    init_req = 1'b0;
    cnt = 0; guard = 0;
    while (busy_obs[0] === 1'b1 && guard < 20) begin
      cnt++;
      cycle("sweep3");
      guard++;
    end
    chk("restart busy cycles", 32'(cnt), 32'd8);

    // Debug wrap on DEPTH=5
    for (int i = 0; i < 5; i++) begin
      sr = 1'b1; s_sel = AW'(i); s_bus = W'(i + 1);
      cycle("dbg_fill");
    end
    sr = 1'b0;
    for (int j = 0; j < 7; j++) begin
      dbg_step = (j < 6);
      cycle("dbg");
      if (j < 6) chk($sformatf("dbg sel step%0d", j), 32'(sel_obs[3]), 32'(exp_sel[j]));
      if (j >= 1) chk($sformatf("dbg data step%0d", j - 1), 32'(d_obs[3]), 32'(exp_data[j - 1]));
    end
    dbg_step = 1'b0;

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      clr      = ($urandom_range(0, 79) == 0);
      sr       = ($urandom_range(0, 1) == 1);
      s_sel    = AW'($urandom_range(0, 7));
      s_bus    = W'($urandom);
      ra       = ($urandom_range(0, 3) != 0);
      a_sel    = ($urandom_range(0, 3) == 0) ? s_sel : AW'($urandom_range(0, 7));
      rb       = ($urandom_range(0, 3) != 0);
      b_sel    = ($urandom_range(0, 3) == 0) ? s_sel : AW'($urandom_range(0, 7));
      init_req = ($urandom_range(0, 29) == 0);
      dbg_step = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
